// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending (busy) bits.
// Combinational reads with optional same-cycle write forwarding and a hard-wired zero register.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rbusy,
  input  logic [NWR-1:0]          we,
  input  logic [NWR*ADDR_W-1:0]   wa,
  input  logic [NWR*DATA_W-1:0]   wd,
  input  logic                    bset,
  input  logic [ADDR_W-1:0]       bset_a
);

  localparam int unsigned NREG    = 2 ** ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);
  localparam bit          BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;

  logic [ADDR_W-1:0] w_wa [NWR];
  logic [DATA_W-1:0] w_wd [NWR];
  logic [NWR-1:0]    w_wr_en;
  logic              w_bset_en;

  // Unpack write ports; writes to the zero register are dropped here so
  // neither storage nor forwarding ever sees them.
  for (genvar j = 0; j < NWR; j++) begin : g_wport
    assign w_wa[j]    = wa[j*ADDR_W +: ADDR_W];
    assign w_wd[j]    = wd[j*DATA_W +: DATA_W];
    assign w_wr_en[j] = we[j] & ~(ZERO_EN & (w_wa[j] == '0));
  end

  assign w_bset_en = bset & ~(ZERO_EN & (bset_a == '0));

  // Storage and busy bits; later ports overwrite earlier ones, and bset is
  // applied last so it wins over a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin : p_store
    if (!reset) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        r_mem[k] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (w_wr_en[j]) begin
          r_mem[w_wa[j]]  <= w_wd[j];
          r_busy[w_wa[j]] <= 1'b0;
        end
      end
      if (w_bset_en) begin
        r_busy[bset_a] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;

    assign w_ra = ra[i*ADDR_W +: ADDR_W];

    // Highest-index matching write port supplies the forwarded data.
    always_comb begin : p_bypass
      w_hit = 1'b0;
      w_byp = '0;
      for (int unsigned j = 0; j < NWR; j++) begin
        if (w_wr_en[j] && (w_wa[j] == w_ra)) begin
          w_hit = 1'b1;
          w_byp = w_wd[j];
        end
      end
    end

    always_comb begin : p_read
      w_rd = r_mem[w_ra];
      w_rb = r_busy[w_ra];
      if (BYP_EN && w_hit) begin
        w_rd = w_byp;
        w_rb = 1'b0;
      end
      if (!reset || (ZERO_EN && (w_ra == '0))) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end

    assign rd[i*DATA_W +: DATA_W] = w_rd;
    assign rbusy[i]               = w_rb;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; depth NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, number of write ports.
REQ-005 The block SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-006 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-007 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-009 The block SHALL have port ra, input, NRD*ADDR_W bits, read addresses; port i is ra[i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rd, output, NRD*DATA_W bits, read data; port i is rd[i*DATA_W +: DATA_W].
REQ-011 The block SHALL have port rbusy, output, NRD bits, pending-write flag of each read address.
REQ-012 The block SHALL have port we, input, NWR bits, per-port write enables.
REQ-013 The block SHALL have port wa, input, NWR*ADDR_W bits, write addresses, packed like ra.
REQ-014 The block SHALL have port wd, input, NWR*DATA_W bits, write data, packed like rd.
REQ-015 The block SHALL have port bset, input, 1 bit, marks register bset_a as pending on the next clock edge.
REQ-016 The block SHALL have port bset_a, input, ADDR_W bits, address marked pending.

Function
REQ-017 On a rising clk edge with reset high, the block SHALL write wd port j into register wa port j for every j where we[j]=1; when ZERO_REG=1, writes to address 0 SHALL have no effect.
REQ-018 When two or more enabled write ports target the same address in one cycle, the block SHALL store the data of the highest-index port only.
REQ-019 The block SHALL drive reads combinationally with zero-cycle latency: rd port i SHALL equal the stored value of register ra port i.
REQ-020 When BYPASS=1 and an enabled write targets ra port i in the current cycle, rd port i SHALL instead carry that write's wd, using the highest-index port on collision.
REQ-021 When ZERO_REG=1 and ra port i = 0, rd port i SHALL be 0 and rbusy[i] SHALL be 0 regardless of writes, bypass or bset.
REQ-022 The block SHALL hold one busy bit per register, and rbusy[i] SHALL equal the busy bit of ra port i.
REQ-023 When BYPASS=1, rbusy[i] SHALL be forced to 0 in any cycle that a bypass hit occurs on port i.
REQ-024 On a clk edge, an enabled write to address A SHALL clear busy[A].
REQ-025 On a clk edge with bset=1, the block SHALL set busy[bset_a], and set SHALL win over a same-edge clear of the same address.
REQ-026 When ZERO_REG=1, the block SHALL ignore bset with bset_a=0.
REQ-027 Read ports SHALL be fully independent, and any number of them, including all, may address the same register.

Reset
REQ-028 While reset is low, the block SHALL clear all registers to 0 and all busy bits to 0 asynchronously, without waiting for clk.
REQ-029 While reset is low, the block SHALL ignore writes and bset, and rd SHALL read 0 with no bypass.
REQ-030 rbusy SHALL be 0 during reset.
REQ-031 On reset release, the first write SHALL occur on the first rising clk edge that sees reset high.
REQ-032 Assertion of reset in the middle of any sequence SHALL discard all pending state, leaving no partial writes or busy bits.

Verification
REQ-033 Reset, then we=01, wa0=3, wd0=0xDEADBEEF, one edge, then ra0=3 -> rd0=0xDEADBEEF and rbusy0=0.
REQ-034 we=11, wa0=wa1=7, wd0=0x11, wd1=0x22, ra0=7 in the same cycle -> rd0=0x22 via bypass before the edge, and stored value 0x22 after the edge.
REQ-035 Write 0x55 to r0 with ra0=0 -> rd0=0 both before and after the edge; with ZERO_REG=0, rd0=0x55 after the edge.
REQ-036 bset=1, bset_a=9, one edge -> rbusy=1 on ra=9; then write r9=0xA5 -> rbusy=0 in that cycle (bypass) and after the edge; bset of r9 on the same edge as a write to r9 -> busy remains 1.
REQ-037 Load r1..r4 with nonzero values, assert reset between clock edges -> all rd=0 and rbusy=0 immediately; release reset, read r1..r4 -> 0.
